// File: rtl/spi_arbiter_pkg.sv
// Shared constants for the SPI master arbiter: FSM encoding, default frame width
// and the index-width helper used by the arbiter and its priority selector.
package spi_arbiter_pkg;

    localparam int DEFAULT_DATA_SIZE = 40;

    localparam logic [2:0] ST_SYNC    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_XFER    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority selector: first set request at or above ptr, wrapping
// modulo NUM_REQ. Purely combinational.
module rr_priority_select
    import spi_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rotated;
    logic [IDX_W:0]     sum;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        any     = 1'b0;
        idx     = '0;
        sum     = '0;
        // Bit j of rotated is request (ptr + j) mod NUM_REQ.
        rotated = NUM_REQ'({req, req} >> ptr);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any && rotated[j]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IDX_W+1)'(j);
                idx = (int'(sum) >= NUM_REQ) ? IDX_W'(int'(sum) - NUM_REQ) : sum[IDX_W-1:0];
            end
        end
        onehot = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between NUM_REQ requesters, granting one whole frame
// per request in round-robin order and routing the received frame back.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int CS_SIZE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             req_in,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_in,
    input  logic [NUM_REQ*CS_SIZE-1:0]     req_cs_in,
    output logic [NUM_REQ-1:0]             gnt_out,
    output logic [NUM_REQ-1:0]             done_out,
    output logic [NUM_REQ-1:0]             err_out,
    output logic [DATA_SIZE-1:0]           rsp_data_out,
    output logic                           busy_out,
    output logic [DATA_SIZE-1:0]           spi_data_out,
    output logic                           spi_send_enable_out,
    output logic [CS_SIZE-1:0]             spi_cs_select_out,
    input  logic                           spi_cs_n_in,
    input  logic [DATA_SIZE-1:0]           spi_data_in
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    logic [2:0]           state_q,  state_nx;
    logic [IDX_W-1:0]     ptr_q,    ptr_nx;
    logic [IDX_W-1:0]     winner_q, winner_nx;
    logic [CNT_W-1:0]     cnt_q,    cnt_nx;
    logic [NUM_REQ-1:0]   gnt_q,    gnt_nx;
    logic [NUM_REQ-1:0]   done_q,   done_nx;
    logic [NUM_REQ-1:0]   err_q,    err_nx;
    logic [DATA_SIZE-1:0] rsp_q,    rsp_nx;
    logic [DATA_SIZE-1:0] data_q,   data_nx;
    logic [CS_SIZE-1:0]   cs_q,     cs_nx;
    logic                 en_q,     en_nx;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req    (req_in),
        .ptr    (ptr_q),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_comb begin
        state_nx  = state_q;
        ptr_nx    = ptr_q;
        winner_nx = winner_q;
        cnt_nx    = cnt_q;
        gnt_nx    = gnt_q;
        done_nx   = '0;
        err_nx    = '0;
        rsp_nx    = rsp_q;
        data_nx   = data_q;
        cs_nx     = cs_q;
        en_nx     = en_q;

        case (state_q)
            ST_SYNC: begin
                // Let a frame the master started before our reset run to completion.
                if (spi_cs_n_in) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (sel_any) begin
                    winner_nx = sel_idx;
                    gnt_nx    = sel_onehot;
                    en_nx     = 1'b1;
                    state_nx  = ST_START;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel_onehot[i]) begin
                            data_nx = req_data_in[i*DATA_SIZE +: DATA_SIZE];
                            cs_nx   = req_cs_in[i*CS_SIZE +: CS_SIZE];
                        end
                    end
                end
            end
            ST_START: begin
                cnt_nx = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
                if (!spi_cs_n_in) begin
                    en_nx    = 1'b0;
                    state_nx = ST_XFER;
                end else if (cnt_nx == CNT_LIMIT) begin
                    en_nx    = 1'b0;
                    err_nx   = gnt_q;
                    state_nx = ST_RELEASE;
                end
            end
            ST_XFER: begin
                if (spi_cs_n_in) begin
                    rsp_nx   = spi_data_in;
                    done_nx  = gnt_q;
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                gnt_nx   = '0;
                ptr_nx   = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: registers use non-blocking assignment so every flop samples the
        // values from before this edge, independent of statement order.
        if (reset_in) begin
            state_q  <= ST_SYNC;
            ptr_q    <= '0;
            winner_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rsp_q    <= '0;
            data_q   <= '0;
            cs_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            ptr_q    <= ptr_nx;
            winner_q <= winner_nx;
            cnt_q    <= cnt_nx;
            gnt_q    <= gnt_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
            rsp_q    <= rsp_nx;
            data_q   <= data_nx;
            cs_q     <= cs_nx;
            en_q     <= en_nx;
            busy_q   <= (state_nx != ST_IDLE);
        end
    end

    assign gnt_out             = gnt_q;
    assign done_out            = done_q;
    assign err_out             = err_q;
    assign rsp_data_out        = rsp_q;
    assign busy_out            = busy_q;
    assign spi_data_out        = data_q;
    assign spi_send_enable_out = en_q;
    assign spi_cs_select_out   = cs_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: table of round-robin transactions against a
// small SPI master model, plus timeout, reset-abort and withdrawn-request cases.
module tb_spi_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 40;
    localparam int TO   = 16;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
        logic            cs;
        logic [DW-1:0]   rsp;
    } vec_t;

    localparam logic [DW-1:0] D0 = 40'h1111111111;
    localparam logic [DW-1:0] D1 = 40'hEC000100C3;
    localparam logic [DW-1:0] D2 = 40'h2222222222;

    logic              clk_in = 1'b0;
    logic              reset_in = 1'b1;
    logic [NREQ-1:0]   req_in = '0;
    logic [NREQ*DW-1:0] req_data_in = {D2, D1, D0};
    logic [NREQ-1:0]   req_cs_in = 3'b101;
    logic [NREQ-1:0]   gnt_out, done_out, err_out;
    logic [DW-1:0]     rsp_data_out, spi_data_out;
    logic              busy_out, spi_send_enable_out;
    logic [0:0]        spi_cs_select_out;
    logic              spi_cs_n_in = 1'b1;
    logic [DW-1:0]     spi_data_in = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // SPI master model state
    int          m_phase = 0;
    int          m_wait  = 0;
    int          m_left  = 0;
    int          m_delay = 2;
    int          m_len   = 3;
    bit          m_hang  = 1'b0;
    logic [DW-1:0] m_rsp = '0;

    spi_arbiter #(
        .NUM_REQ   (NREQ),
        .DATA_SIZE (DW),
        .CS_SIZE   (1),
        .TIMEOUT   (TO)
    ) dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .req_in              (req_in),
        .req_data_in         (req_data_in),
        .req_cs_in           (req_cs_in),
        .gnt_out             (gnt_out),
        .done_out            (done_out),
        .err_out             (err_out),
        .rsp_data_out        (rsp_data_out),
        .busy_out            (busy_out),
        .spi_data_out        (spi_data_out),
        .spi_send_enable_out (spi_send_enable_out),
        .spi_cs_select_out   (spi_cs_select_out),
        .spi_cs_n_in         (spi_cs_n_in),
        .spi_data_in         (spi_data_in)
    );

    always #5 clk_in = ~clk_in;

    // Master: after enable, drop CS after m_delay cycles, hold it low m_len cycles,
    // then raise it with the response on the data lines. Frames run to completion.
    always @(negedge clk_in) begin
        case (m_phase)
            0: if (spi_send_enable_out && !m_hang) begin
                m_wait  = m_delay;
                m_phase = 1;
            end
            1: if (m_wait == 0) begin
                spi_cs_n_in = 1'b0;
                spi_data_in = ~m_rsp;
                m_left      = m_len;
                m_phase     = 2;
            end else begin
                m_wait = m_wait - 1;
            end
            default: if (m_left == 0) begin
                spi_cs_n_in = 1'b1;
                spi_data_in = m_rsp;
                m_phase     = 0;
            end else begin
                m_left = m_left - 1;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (gnt_out != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            if (done_out != '0 || err_out != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_xfer(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (!spi_send_enable_out) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_txn(input vec_t v, input logic [NREQ-1:0] req_after);
        bit ok;
        m_rsp  = v.rsp;
        req_in = v.req;
        wait_gnt(ok);
        check("grant_seen", 64'(ok), 64'd1);
        check("gnt", 64'(gnt_out), 64'(v.gnt));
        check("spi_data", 64'(spi_data_out), 64'(v.data));
        check("cs_select", 64'(spi_cs_select_out), 64'(v.cs));
        check("send_enable", 64'(spi_send_enable_out), 64'd1);
        check("busy", 64'(busy_out), 64'd1);
        wait_resp(ok);
        check("resp_seen", 64'(ok), 64'd1);
        check("done", 64'(done_out), 64'(v.gnt));
        check("err_quiet", 64'(err_out), 64'd0);
        check("rsp_data", 64'(rsp_data_out), 64'(v.rsp));
        check("gnt_held", 64'(gnt_out), 64'(v.gnt));
        req_in = req_after;
        @(negedge clk_in);
        check("done_one_cycle", 64'(done_out), 64'd0);
        check("gnt_released", 64'(gnt_out), 64'd0);
    endtask

    vec_t vecs [0:12];

    initial begin
        bit ok;
        bit bad;
        int en_cycles;

        vecs[0]  = '{3'b111, 3'b001, D0, 1'b1, 40'h00000000A0};
        vecs[1]  = '{3'b111, 3'b010, D1, 1'b0, 40'h00000000A1};
        vecs[2]  = '{3'b111, 3'b100, D2, 1'b1, 40'h00000000A2};
        vecs[3]  = '{3'b111, 3'b001, D0, 1'b1, 40'h00000000A3};
        vecs[4]  = '{3'b111, 3'b010, D1, 1'b0, 40'h00000000A4};
        vecs[5]  = '{3'b111, 3'b100, D2, 1'b1, 40'h00000000A5};
        vecs[6]  = '{3'b010, 3'b010, D1, 1'b0, 40'h0000000055};
        vecs[7]  = '{3'b100, 3'b100, D2, 1'b1, 40'h5A5A5A5A5A};
        vecs[8]  = '{3'b101, 3'b001, D0, 1'b1, 40'hFFFFFFFFFF};
        vecs[9]  = '{3'b101, 3'b100, D2, 1'b1, 40'h8000000001};
        vecs[10] = '{3'b011, 3'b001, D0, 1'b1, 40'h0123456789};
        vecs[11] = '{3'b110, 3'b010, D1, 1'b0, 40'h9876543210};
        vecs[12] = '{3'b011, 3'b001, D0, 1'b1, 40'hC3C3C3C3C3};

        repeat (3) @(negedge clk_in);
        check("rst_gnt", 64'(gnt_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_enable", 64'(spi_send_enable_out), 64'd0);
        check("rst_rsp", 64'(rsp_data_out), 64'd0);
        reset_in = 1'b0;

        for (int i = 0; i < 13; i++)
            run_txn(vecs[i], (i < 12) ? vecs[i+1].req : 3'b000);

        // Timeout: master never answers; enable must stay high exactly TO cycles.
        m_hang = 1'b1;
        req_in = 3'b001;
        wait_gnt(ok);
        check("to_grant", 64'(gnt_out), 64'b001);
        en_cycles = 0;
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!spi_send_enable_out) break;
            en_cycles++;
            if (done_out != '0 || err_out != '0) bad = 1'b1;
            @(negedge clk_in);
        end
        check("to_enable_cycles", 64'(en_cycles), 64'(TO));
        check("to_early_pulse", 64'(bad), 64'd0);
        check("to_err", 64'(err_out), 64'b001);
        check("to_no_done", 64'(done_out), 64'd0);
        req_in = '0;
        m_hang = 1'b0;
        @(negedge clk_in);
        check("to_err_one_cycle", 64'(err_out), 64'd0);
        run_txn('{3'b100, 3'b100, D2, 1'b1, 40'h7777777777}, 3'b000);

        // Reset during XFER with CS held low for many more cycles.
        m_len  = 25;
        m_rsp  = 40'h1234512345;
        req_in = 3'b010;
        wait_gnt(ok);
        check("rx_grant", 64'(gnt_out), 64'b010);
        wait_xfer(ok);
        check("rx_in_xfer", 64'(ok), 64'd1);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        check("rx_gnt_zero", 64'(gnt_out), 64'd0);
        check("rx_busy_zero", 64'(busy_out), 64'd0);
        check("rx_rsp_zero", 64'(rsp_data_out), 64'd0);
        check("rx_data_zero", 64'(spi_data_out), 64'd0);
        check("rx_done_zero", 64'(done_out), 64'd0);
        check("rx_cs_still_low", 64'(spi_cs_n_in), 64'd0);
        m_len = 3;
        bad = 1'b0;
        ok  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (done_out != '0) bad = 1'b1;
            if (gnt_out != '0) begin
                ok = 1'b1;
                if (!spi_cs_n_in) bad = 1'b1;
                break;
            end
        end
        check("rx_regrant", 64'(ok), 64'd1);
        check("rx_no_grant_during_frame", 64'(bad), 64'd0);
        check("rx_gnt_after", 64'(gnt_out), 64'b010);
        wait_resp(ok);
        check("rx_done_after", 64'(done_out), 64'b010);
        check("rx_rsp_after", 64'(rsp_data_out), 64'(m_rsp));
        req_in = '0;
        repeat (2) @(negedge clk_in);

        // Request withdrawn mid-transfer still completes.
        m_rsp  = 40'h00DEADBEEF;
        req_in = 3'b010;
        wait_gnt(ok);
        check("wd_grant", 64'(gnt_out), 64'b010);
        wait_xfer(ok);
        req_in = '0;
        wait_resp(ok);
        check("wd_resp_seen", 64'(ok), 64'd1);
        check("wd_done", 64'(done_out), 64'b010);
        check("wd_rsp", 64'(rsp_data_out), 64'h00DEADBEEF);
        @(negedge clk_in);
        check("wd_idle_gnt", 64'(gnt_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI master (40-bit frames, active-low CS) between NUM_REQ requesters, e.g. driver setup sequencer, status poller and host command path.
- Round-robin grant, one whole frame per grant.
- Drives the master's send-enable, data and CS select; returns the received frame to the granted requester.
- Sits between requester FSMs and the spi instance inside the motor driver subsystem.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_SIZE, 40, SPI frame width.
- CS_SIZE, 1, width of the CS select index.
- TIMEOUT, 255, max cycles to wait for the master's CS to go low after start (1..65535).

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous active-high reset
- req_in  input  NUM_REQ  request per requester, level
- req_data_in  input  NUM_REQ*DATA_SIZE  frame per requester; slice i = bits [i*DATA_SIZE +: DATA_SIZE]
- req_cs_in  input  NUM_REQ*CS_SIZE  CS index per requester
- gnt_out  output  NUM_REQ  one-hot grant, held for the whole transaction
- done_out  output  NUM_REQ  one-cycle completion pulse to the granted requester
- err_out  output  NUM_REQ  one-cycle timeout pulse to the granted requester
- rsp_data_out  output  DATA_SIZE  received frame; valid from the done pulse until the next done
- busy_out  output  1  high in every state except IDLE
- spi_data_out  output  DATA_SIZE  to master data_in
- spi_send_enable_out  output  1  to master send_enable_in
- spi_cs_select_out  output  CS_SIZE  to master cs_select_in
- spi_cs_n_in  input  1  master cs_out_n; high = idle
- spi_data_in  input  DATA_SIZE  master data_out

Behaviour:
- Single clock clk_in. Reset is synchronous, active-high, on reset_in. No other reset path.
- Reset values: all outputs 0; rr pointer 0; timeout counter 0; state SYNC.
- States:
  - SYNC: wait until spi_cs_n_in is high, then go to IDLE. This covers a master still mid-frame after an arbiter-only reset.
  - IDLE: if any req_in is set, choose the first set bit searching from pointer p upward, modulo NUM_REQ. Latch the winner index, its req_data_in slice into spi_data_out and its req_cs_in slice into spi_cs_select_out. Set gnt_out one-hot. Go to START. Decision and grant take one cycle.
  - START: spi_send_enable_out=1 and the counter increments.
    - When spi_cs_n_in is low: drop enable next cycle, go to XFER.
    - When the counter reaches TIMEOUT with CS still high: drop enable, pulse err_out[winner], go to RELEASE.
  - XFER: spi_send_enable_out=0. Wait for spi_cs_n_in high, then capture spi_data_in into rsp_data_out, pulse done_out[winner] for 1 cycle, go to RELEASE.
  - RELEASE: clear gnt_out, set p = winner+1 (wrap to 0 after NUM_REQ-1), clear the counter, go to IDLE.
- Fairness: a requester holding req_in continuously cannot win twice in a row while another request is pending.
- Minimum gap between grants: 2 cycles (RELEASE, IDLE).
- Requester obligations:
  - Hold the data slice stable from req rise until grant; it is latched at grant, so later changes are ignored.
  - Drop req_in on the cycle after done/err, otherwise it is re-arbitrated.
- req_in dropped while granted: the transaction still completes, and done/err is still pulsed.
- Simultaneous err and done cannot occur: these are exclusive states.
- reset_in mid-transfer: outputs return to 0 next cycle; state SYNC waits out the master's frame before further grants. No done is issued for the aborted frame.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Winner index width is $clog2(NUM_REQ), with a minimum of 1.

Decomposition:
- Package spi_arbiter_pkg: state encoding constants (SYNC, IDLE, START, XFER, RELEASE), default DATA_SIZE 40.
- One sub-module: rr_priority_select, combinational. Inputs: req vector and pointer. Outputs: one-hot winner, index, any. Tested standalone.
- Remaining logic is the FSM plus datapath registers.

Test Plan:
- Single request: req_in=3'b010, data 40'hEC000100C3, cs 0.
  - gnt_out=010 one cycle later; spi_data_out=EC000100C3; enable high until the model drops CS.
  - Model returns 40'h0000000055: done_out=010 for 1 cycle, rsp_data_out=0000000055.
- Simultaneous requests: req_in=3'b111 held.
  - Grant order 0,1,2,0,1,2 across six transactions; never the same index twice in succession.
- Wrap and pointer: after a grant to requester 2, set req_in=3'b101.
  - Next grant goes to 0; after that, pointer=1 and req_in=101 grants 2.
- Timeout: master model never drops CS, TIMEOUT=16.
  - err_out pulses on the 16th START cycle; enable low next cycle; done never pulses; next request is served normally.
- Reset mid-transfer: assert reset_in during XFER while the model keeps CS low for 20 more cycles.
  - All outputs 0 the next cycle; no grant until CS returns high; then normal service resumes.
- Withdrawn request: drop req_in[1] during XFER.
  - Transaction completes and done_out[1] still pulses.
